ps2_inreg: RTL and testbench

Receives a PS/2 keyboard stream (scan-code set 2) and encodes key state into the gigatron's active-low 8-bit `inreg` controller byte, replacing the constant 8'hFF stub at the top level. Sits between the board PS/2 pins and the CPU `inreg` input, clocked by the 6.25 MHz CPU clock. It deframes serial PS/2 frames, filters the line, and tracks make/break/extended prefixes. It keeps a pressed/released state bit per mapped button.

---
 rtl/ps2_inreg.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_inreg.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_inreg.sv
// PS/2 keyboard receiver mapping scan-code set 2 keys onto the active-low gigatron inreg byte.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not check.
module ps2_inreg #(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 6250
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] inreg,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int             FW   = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [FW-1:0]  FLIM = FW'(FILTER - 1);
  localparam logic [15:0]    TLIM = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          clk_p0, clk_p1;
  logic          dat_p0, dat_p1;
  logic          level;
  logic [FW-1:0] fcnt;
  logic          fall;
  logic [15:0]   idle_cnt;
  logic          timeout;

  state_t        state, state_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shift, shift_nx;
  logic          frame_ok;
  logic          accept, reject;
  logic          brk, ext;
  logic [3:0]    map;

  // Returns {hit, bit index} for a scan code given the extended-prefix state.
  function automatic logic [3:0] key_map(input logic ext_f, input logic [7:0] b);
    logic [3:0] r;
    r = 4'b0000;
    case ({ext_f, b})
      9'h175:  r = 4'b1011;
      9'h172:  r = 4'b1010;
      9'h16B:  r = 4'b1001;
      9'h174:  r = 4'b1000;
      9'h01C:  r = 4'b1111;
      9'h032:  r = 4'b1110;
      9'h00D:  r = 4'b1101;
      9'h05A:  r = 4'b1100;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Stage p0/p1: two-flop synchronizers, idle-high so reset looks like an idle line
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_dat;
      dat_p1 <= dat_p0;
    end
  end

  // Filtered clock level: flips only after FILTER consecutive disagreeing samples
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      fcnt  <= '0;
    end else if (clk_p1 != level) begin
      if (fcnt == FLIM) begin
        level <= ~level;
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end else begin
      fcnt <= '0;
    end
  end

  assign fall = level & ~clk_p1 & (fcnt == FLIM);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state == S_IDLE || fall || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign timeout = (state != S_IDLE) && (idle_cnt == TLIM);

`ifdef PS2_PARITY_CHECK_EN
  logic par, par_nx;
  assign frame_ok = dat_p1 & (^{shift, par});
`else
  assign frame_ok = dat_p1;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
    end
  end

  // Shift register holds data only; a stale value is never accepted without 8 new bits
  always_ff @(posedge clock) begin
    shift <= shift_nx;
`ifdef PS2_PARITY_CHECK_EN
    par   <= par_nx;
`endif
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
`ifdef PS2_PARITY_CHECK_EN
    par_nx     = par;
`endif
    accept     = 1'b0;
    reject     = 1'b0;
    if (timeout) begin
      state_nx = S_IDLE;
      reject   = 1'b1;
    end else if (fall) begin
      case (state)
        S_IDLE: begin
          if (!dat_p1) begin
            state_nx   = S_DATA;
            bit_cnt_nx = 3'd0;
          end
        end
        S_DATA: begin
          shift_nx = {dat_p1, shift[7:1]};
          if (bit_cnt == 3'd7) state_nx = S_PARITY;
          else                 bit_cnt_nx = bit_cnt + 3'd1;
        end
        S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_nx   = dat_p1;
`endif
          state_nx = S_STOP;
        end
        S_STOP: begin
          state_nx = S_IDLE;
          if (frame_ok) accept = 1'b1;
          else          reject = 1'b1;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign map = key_map(ext, shift);

  // Stage p2: decoder, output byte and status pulses
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      inreg      <= 8'hFF;
      code       <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      brk        <= 1'b0;
      ext        <= 1'b0;
    end else begin
      code_valid <= accept;
      frame_err  <= reject;
      if (accept) begin
        code <= shift;
        if (shift == 8'hF0) begin
          brk <= 1'b1;
        end else if (shift == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (map[3]) inreg[map[2:0]] <= brk;
        end
      end else if (reject) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_inreg.sv
// Scoreboard bench for ps2_inreg: frames push expected events, a monitor records DUT pulses.
`timescale 1ns/1ps
module tb_ps2_inreg;

  logic       clock;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] inreg;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  ps2_inreg dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .inreg      (inreg),
    .code       (code),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  // kind: 0 code_valid, 1 frame_err, 2 both at once, 3 nothing observed
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] code;
    logic [7:0] inr;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  ev_t        mon_ev;
  logic [7:0] last_code;
  int         n_cmp;
  int         n_bad;

  initial clock = 1'b0;
  always #80 clock = ~clock;

  always @(negedge clock) begin
    if (code_valid || frame_err) begin
      mon_ev.kind = (code_valid && frame_err) ? 2'd2 : (frame_err ? 2'd1 : 2'd0);
      mon_ev.code = code;
      mon_ev.inr  = inreg;
      obs_q.push_back(mon_ev);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_ok(input logic [7:0] c, input logic [7:0] r);
    ev_t e;
    e.kind = 2'd0; e.code = c; e.inr = r;
    exp_q.push_back(e);
    last_code = c;
  endtask

  task automatic push_err(input logic [7:0] r);
    ev_t e;
    e.kind = 2'd1; e.code = last_code; e.inr = r;
    exp_q.push_back(e);
  endtask

  function automatic ev_t pop_obs();
    ev_t e;
    e.kind = 2'd3; e.code = 8'h00; e.inr = 8'h00;
    if (obs_q.size() > 0) e = obs_q.pop_front();
    return e;
  endfunction

  task automatic wait_obs(input int budget);
    int t;
    t = 0;
    while (obs_q.size() < exp_q.size() && t < budget) begin
      tick(1);
      t++;
    end
    tick(20);
  endtask

  // nbits < 11 sends a truncated frame; bits are start, 8 data LSB first, parity, stop
  task automatic send_frame(input logic [7:0] b, input int half, input int nbits,
                            input bit bad_stop, input bit bad_par, input bit glitch);
    logic [10:0] bits;
    logic        p;
    p = ~^b;
    if (bad_par) p = ~p;
    bits = {~bad_stop, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      if (glitch && i == 3) begin
        tick(half / 2); ps2_clk = 1'b0; tick(1); ps2_clk = 1'b1; tick(half - half / 2 - 1);
      end else begin
        tick(half);
      end
      ps2_clk = 1'b0;
      if (glitch && i == 5) begin
        tick(half / 2); ps2_clk = 1'b1; tick(1); ps2_clk = 1'b0; tick(half - half / 2 - 1);
      end else begin
        tick(half);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    tick(2 * half);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 40, 11, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({inreg, code, code_valid, frame_err} !== {8'hFF, 8'h00, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_during: got inreg=%h code=%h cv=%b fe=%b, want FF 00 0 0",
               inreg, code, code_valid, frame_err);
    end
    rst_n = 1'b1;
    tick(10000);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_idle_pulses: got %0d pulses, want 0", obs_q.size());
    end
    n_cmp++;
    if (inreg !== 8'hFF || code !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_idle_out: got inreg=%h code=%h, want FF 00", inreg, code);
    end
  endtask

  task automatic test_basic;
    ev_t o, e;
    push_ok(8'h1C, 8'h7F); send_frame(8'h1C, 312, 11, 1'b0, 1'b0, 1'b0);
    push_ok(8'hF0, 8'h7F); send_frame(8'hF0, 312, 11, 1'b0, 1'b0, 1'b0);
    push_ok(8'h1C, 8'hFF); send_frame(8'h1C, 313, 11, 1'b0, 1'b0, 1'b0);
    wait_obs(2000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = pop_obs(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL basic[%0d]: got kind=%0d code=%h inreg=%h, want kind=%0d code=%h inreg=%h",
                 i, o.kind, o.code, o.inr, e.kind, e.code, e.inr);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL basic_extra: got %0d extra pulses, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_extended;
    ev_t o, e;
    push_ok(8'hE0, 8'hFF); send(8'hE0);
    push_ok(8'h75, 8'hF7); send(8'h75);
    push_ok(8'hE0, 8'hF7); send(8'hE0);
    push_ok(8'h74, 8'hF6); send(8'h74);
    push_ok(8'hE0, 8'hF6); send(8'hE0);
    push_ok(8'hF0, 8'hF6); send(8'hF0);
    push_ok(8'h75, 8'hFE); send(8'h75);
    push_ok(8'h75, 8'hFE); send(8'h75);
    push_ok(8'hE0, 8'hFE); send(8'hE0);
    push_ok(8'h74, 8'hFE); send(8'h74);
    push_ok(8'hE0, 8'hFE); send(8'hE0);
    push_ok(8'hF0, 8'hFE); send(8'hF0);
    push_ok(8'h74, 8'hFF); send(8'h74);
    push_ok(8'hE0, 8'hFF); send(8'hE0);
    push_ok(8'h5A, 8'hFF); send(8'h5A);
    push_ok(8'h15, 8'hFF); send(8'h15);
    wait_obs(2000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = pop_obs(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL extended[%0d]: got kind=%0d code=%h inreg=%h, want kind=%0d code=%h inreg=%h",
                 i, o.kind, o.code, o.inr, e.kind, e.code, e.inr);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL extended_extra: got %0d extra pulses, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_errors;
    ev_t o, e;
    push_err(8'hFF);       send_frame(8'h5A, 40, 11, 1'b1, 1'b0, 1'b0);
    push_ok(8'hF0, 8'hFF); send(8'hF0);
    push_err(8'hFF);       send_frame(8'h33, 40, 11, 1'b1, 1'b0, 1'b0);
    push_ok(8'h1C, 8'h7F); send(8'h1C);
    push_ok(8'hF0, 8'h7F); send(8'hF0);
    push_ok(8'h1C, 8'hFF); send(8'h1C);
`ifdef PS2_PARITY_CHECK_EN
    push_err(8'hFF);
`else
    push_ok(8'h5A, 8'hEF);
`endif
    send_frame(8'h5A, 40, 11, 1'b0, 1'b1, 1'b0);
    push_ok(8'hF0, exp_q[exp_q.size() - 1].inr); send(8'hF0);
    push_ok(8'h5A, 8'hFF); send(8'h5A);
    wait_obs(2000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = pop_obs(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL errors[%0d]: got kind=%0d code=%h inreg=%h, want kind=%0d code=%h inreg=%h",
                 i, o.kind, o.code, o.inr, e.kind, e.code, e.inr);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL errors_extra: got %0d extra pulses, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_timeout;
    ev_t o, e;
    push_err(8'hFF);
    send_frame(8'h32, 40, 5, 1'b0, 1'b0, 1'b0);
    tick(7000);
    push_ok(8'h32, 8'hBF); send(8'h32);
    wait_obs(2000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = pop_obs(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL timeout[%0d]: got kind=%0d code=%h inreg=%h, want kind=%0d code=%h inreg=%h",
                 i, o.kind, o.code, o.inr, e.kind, e.code, e.inr);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL timeout_extra: got %0d extra pulses, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_glitch;
    ev_t o, e;
    push_ok(8'hE0, 8'hBF); send_frame(8'hE0, 40, 11, 1'b0, 1'b0, 1'b1);
    push_ok(8'h6B, 8'hBD); send_frame(8'h6B, 40, 11, 1'b0, 1'b0, 1'b1);
    wait_obs(2000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = pop_obs(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL glitch[%0d]: got kind=%0d code=%h inreg=%h, want kind=%0d code=%h inreg=%h",
                 i, o.kind, o.code, o.inr, e.kind, e.code, e.inr);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL glitch_extra: got %0d extra pulses, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_mid_reset;
    ev_t o, e;
    send_frame(8'h1C, 40, 5, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(3);
    n_cmp++;
    if ({inreg, code, code_valid, frame_err} !== {8'hFF, 8'h00, 2'b00}) begin
      n_bad++;
      $display("FAIL mid_reset_out: got inreg=%h code=%h cv=%b fe=%b, want FF 00 0 0",
               inreg, code, code_valid, frame_err);
    end
    rst_n = 1'b1;
    last_code = 8'h00;
    tick(8000);
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL mid_reset_pulses: got %0d pulses, want 0", obs_q.size()); obs_q.delete(); end
    push_ok(8'h1C, 8'h7F); send(8'h1C);
    wait_obs(2000);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = pop_obs(); n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL mid_reset[%0d]: got kind=%0d code=%h inreg=%h, want kind=%0d code=%h inreg=%h",
                 i, o.kind, o.code, o.inr, e.kind, e.code, e.inr);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL mid_reset_extra: got %0d extra pulses, want 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    last_code = 8'h00;
    rst_n     = 1'b0;
    ps2_clk   = 1'b1;
    ps2_dat   = 1'b1;
    tick(5);
    test_reset;
    test_basic;
    test_extended;
    test_errors;
    test_timeout;
    test_glitch;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
